mem_arbiter: RTL and testbench

Two-port arbiter that shares the multi-cycle processor's single unified memory between the CPU core and a program loader/debug port. Each requester issues one access at a time through a req/ack handshake. The arbiter selects a winner, drives the memory for a fixed number of latency cycles, registers read data, and pulses ack. It sits between the CPU's memory interface (MemRead/MemWrite/IorD-selected address) and the memory array, and lets instructions be loaded into memory while the core runs or is held.

---
 rtl/cpu_pkg.sv | 16 +
 rtl/arb_pick.sv | 32 +++
 rtl/mem_arbiter.sv | 117 +++++++++++
 tb/tb_mem_arbiter.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared constants and types for the multi-cycle CPU memory subsystem.
package cpu_pkg;

    localparam int unsigned DW_DEF = 16;
    localparam int unsigned AW_DEF = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arb_state_e;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_LDR = 1'b1;

endpackage

// File: rtl/arb_pick.sv
// Combinational winner selection between the CPU and loader request lines.
// MEM_ARB_RR_EN selects round-robin tie-breaking; otherwise the CPU wins ties.
module arb_pick
    import cpu_pkg::*;
(
    input  logic c_req,
    input  logic l_req,
    input  logic last_owner,
    output logic grant_valid,
    output logic grant_id
);

    always_comb begin
        grant_valid = c_req | l_req;
        grant_id    = PORT_CPU;
        if (c_req && l_req) begin
`ifdef MEM_ARB_RR_EN
            grant_id = ~last_owner;
`else
            grant_id = PORT_CPU;
`endif
        end else if (l_req) begin
            grant_id = PORT_LDR;
        end
    end

`ifndef MEM_ARB_RR_EN
    logic unused_last_owner;
    assign unused_last_owner = last_owner;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares the unified memory between the CPU core and the loader/debug port.
// Define MEM_ARB_RR_EN for round-robin tie-breaking (fixed CPU priority otherwise).
module mem_arbiter
    import cpu_pkg::*;
#(
    parameter int unsigned DW      = DW_DEF,
    parameter int unsigned AW      = AW_DEF,
    parameter int unsigned MEM_LAT = 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    output logic [DW-1:0] c_rdata,
    output logic          c_ack,
    input  logic          l_req,
    input  logic          l_we,
    input  logic [AW-1:0] l_addr,
    input  logic [DW-1:0] l_wdata,
    output logic [DW-1:0] l_rdata,
    output logic          l_ack,
    output logic          m_en,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata,
    output logic          busy,
    output logic          owner
);

    localparam int unsigned CW = $clog2(MEM_LAT + 1);

    generate
        if (MEM_LAT < 1) begin : g_lat_check
            $error("mem_arbiter: MEM_LAT must be at least 1");
        end
    endgenerate

    arb_state_e    state;
    logic [CW-1:0] cnt;
    logic          last_owner;
    logic          grant_valid;
    logic          grant_id;

    arb_pick u_pick (
        .c_req       (c_req),
        .l_req       (l_req),
        .last_owner  (last_owner),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    assign busy = (state != IDLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            last_owner <= PORT_LDR;
            owner      <= PORT_CPU;
            m_en       <= 1'b0;
            m_we       <= 1'b0;
            m_addr     <= '0;
            m_wdata    <= '0;
            c_rdata    <= '0;
            l_rdata    <= '0;
            c_ack      <= 1'b0;
            l_ack      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        owner      <= grant_id;
                        last_owner <= grant_id;
                        cnt        <= '0;
                        m_en       <= 1'b1;
                        if (grant_id == PORT_LDR) begin
                            m_we    <= l_we;
                            m_addr  <= l_addr;
                            m_wdata <= l_wdata;
                        end else begin
                            m_we    <= c_we;
                            m_addr  <= c_addr;
                            m_wdata <= c_wdata;
                        end
                        state <= ACCESS;
                    end
                end
                ACCESS: begin
                    // Counts up to MEM_LAT at most, which fits CW bits, so no wrap.
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(MEM_LAT - 1)) begin
                        m_en <= 1'b0;
                        m_we <= 1'b0;
                        if (owner == PORT_LDR) begin
                            l_ack <= 1'b1;
                            if (!m_we) l_rdata <= m_rdata;
                        end else begin
                            c_ack <= 1'b1;
                            if (!m_we) c_rdata <= m_rdata;
                        end
                        state <= DONE;
                    end
                end
                DONE: begin
                    c_ack <= 1'b0;
                    l_ack <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized self-checking bench for mem_arbiter against a transaction-level model.
module tb_mem_arbiter;
    import cpu_pkg::*;

    localparam int unsigned DW  = 16;
    localparam int unsigned AW  = 8;
    localparam int unsigned LAT = 3;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          c_req = 1'b0, c_we = 1'b0, l_req = 1'b0, l_we = 1'b0;
    logic [AW-1:0] c_addr = '0, l_addr = '0;
    logic [DW-1:0] c_wdata = '0, l_wdata = '0;
    logic [DW-1:0] c_rdata, l_rdata, m_wdata, m_rdata;
    logic [AW-1:0] m_addr;
    logic          c_ack, l_ack, m_en, m_we, busy, owner;

    int checks = 0;
    int failures = 0;

    logic [DW-1:0] mem     [256];
    logic [DW-1:0] ref_mem [256];
    logic [DW-1:0] exp_crd, exp_lrd;
    logic          exp_last;

    always #5 clock = ~clock;

    mem_arbiter #(.DW(DW), .AW(AW), .MEM_LAT(LAT)) dut (
        .clock   (clock),
        .reset   (reset),
        .c_req   (c_req),
        .c_we    (c_we),
        .c_addr  (c_addr),
        .c_wdata (c_wdata),
        .c_rdata (c_rdata),
        .c_ack   (c_ack),
        .l_req   (l_req),
        .l_we    (l_we),
        .l_addr  (l_addr),
        .l_wdata (l_wdata),
        .l_rdata (l_rdata),
        .l_ack   (l_ack),
        .m_en    (m_en),
        .m_we    (m_we),
        .m_addr  (m_addr),
        .m_wdata (m_wdata),
        .m_rdata (m_rdata),
        .busy    (busy),
        .owner   (owner)
    );

    // Memory array: asynchronous read, write on the clock edge while enabled.
    assign m_rdata = mem[m_addr];
    always @(posedge clock) if (m_en && m_we) mem[m_addr] = m_wdata;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        check("ack_onehot", 32'(c_ack & l_ack), 0);
        check("busy_state", 32'(busy), 32'(dut.state != IDLE));
    end

    task automatic check_reset_vals();
        check("rst_m_en", 32'(m_en), 0);
        check("rst_m_we", 32'(m_we), 0);
        check("rst_m_addr", 32'(m_addr), 0);
        check("rst_m_wdata", 32'(m_wdata), 0);
        check("rst_c_rdata", 32'(c_rdata), 0);
        check("rst_l_rdata", 32'(l_rdata), 0);
        check("rst_c_ack", 32'(c_ack), 0);
        check("rst_l_ack", 32'(l_ack), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_owner", 32'(owner), 0);
    endtask

    task automatic model_reset();
        exp_crd  = '0;
        exp_lrd  = '0;
        exp_last = 1'b1;
    endtask

    task automatic scramble();
        c_we    = 1'($urandom());
        c_addr  = AW'($urandom_range(0, 15));
        c_wdata = DW'($urandom());
        l_we    = 1'($urandom());
        l_addr  = AW'($urandom_range(0, 15));
        l_wdata = DW'($urandom());
    endtask

    // Entered in an IDLE cycle with the requests already driven; returns in the
    // IDLE cycle following the access, with the winner's request dropped.
    task automatic run_access(input bit drop_mid, output logic win);
        logic          we;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        if (c_req && l_req) begin
`ifdef MEM_ARB_RR_EN
            win = ~exp_last;
`else
            win = 1'b0;
`endif
        end else begin
            win = l_req;
        end
        exp_last = win;
        we = win ? l_we : c_we;
        a  = win ? l_addr : c_addr;
        d  = win ? l_wdata : c_wdata;
        check("idle_busy", 32'(busy), 0);
        for (int k = 1; k <= int'(LAT) + 1; k++) begin
            @(posedge clock);
            #1;
            if (k == 1) begin
                scramble();
                if (drop_mid) begin
                    if (win) l_req = 1'b0;
                    else c_req = 1'b0;
                end
            end
            if (k <= int'(LAT)) begin
                check("acc_m_en", 32'(m_en), 1);
                check("acc_m_we", 32'(m_we), 32'(we));
                check("acc_m_addr", 32'(m_addr), 32'(a));
                if (we) check("acc_m_wdata", 32'(m_wdata), 32'(d));
                check("acc_owner", 32'(owner), 32'(win));
                check("acc_c_ack", 32'(c_ack), 0);
                check("acc_l_ack", 32'(l_ack), 0);
            end else begin
                if (we) ref_mem[a] = d;
                else if (win) exp_lrd = ref_mem[a];
                else exp_crd = ref_mem[a];
                check("done_m_en", 32'(m_en), 0);
                check("done_c_ack", 32'(c_ack), 32'(!win));
                check("done_l_ack", 32'(l_ack), 32'(win));
                check("done_c_rdata", 32'(c_rdata), 32'(exp_crd));
                check("done_l_rdata", 32'(l_rdata), 32'(exp_lrd));
                if (win) l_req = 1'b0;
                else c_req = 1'b0;
            end
        end
        @(posedge clock);
        #1;
        check("post_m_en", 32'(m_en), 0);
        check("post_c_ack", 32'(c_ack), 0);
        check("post_l_ack", 32'(l_ack), 0);
        check("post_c_rdata", 32'(c_rdata), 32'(exp_crd));
        check("post_l_rdata", 32'(l_rdata), 32'(exp_lrd));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        c_req = 1'b0;
        l_req = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        model_reset();
        check_reset_vals();
    endtask

    initial begin
        #400000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        logic    w;
        logic [2:0] exp_pair;
        for (int i = 0; i < 256; i++) begin
            mem[i]     = DW'(i * 257) ^ 16'h5A5A;
            ref_mem[i] = mem[i];
        end
        mem[16]     = 16'hBEEF;
        ref_mem[16] = 16'hBEEF;

        do_reset();

        // CPU read of a known word
        c_req = 1'b1; c_we = 1'b0; c_addr = 8'h10;
        run_access(1'b0, w);
        check("beef_owner", 32'(w), 0);
        check("beef_rdata", 32'(c_rdata), 32'h0000BEEF);

        // Loader write, then CPU reads it back
        l_req = 1'b1; l_we = 1'b1; l_addr = 8'h05; l_wdata = 16'h1234;
        run_access(1'b0, w);
        c_req = 1'b1; c_we = 1'b0; c_addr = 8'h05;
        run_access(1'b0, w);
        check("rd_1234", 32'(c_rdata), 32'h00001234);

        // Three back-to-back simultaneous pairs from a fresh reset
        do_reset();
`ifdef MEM_ARB_RR_EN
        exp_pair = 3'b010;
`else
        exp_pair = 3'b000;
`endif
        for (int p = 0; p < 3; p++) begin
            c_req = 1'b1;
            l_req = 1'b1;
            run_access(1'b0, w);
            check("pair_winner", 32'(w), 32'(exp_pair[2-p]));
        end
        while (c_req || l_req) run_access(1'b0, w);

        // Request dropped during ACCESS: still acked, no second access
        c_req = 1'b1; c_we = 1'b0; c_addr = 8'h03;
        run_access(1'b1, w);
        for (int k = 0; k < 3; k++) begin
            @(posedge clock);
            #1;
            check("drop_no_reissue", 32'(m_en | busy), 0);
        end

        // Randomized traffic
        for (int it = 0; it < 60; it++) begin
            scramble();
            c_req = 1'($urandom());
            l_req = 1'($urandom());
            if (!c_req && !l_req) c_req = 1'b1;
            while (c_req || l_req) run_access(1'b0, w);
            repeat ($urandom_range(0, 2)) @(posedge clock);
            #0;
        end

        // Reset asserted in the second ACCESS cycle
        c_req = 1'b1; c_we = 1'b0; c_addr = 8'h10;
        @(posedge clock); #1;
        @(posedge clock); #1;
        check("pre_rst_m_en", 32'(m_en), 1);
        reset = 1'b1;
        c_req = 1'b0;
        @(posedge clock); #1;
        reset = 1'b0;
        model_reset();
        check_reset_vals();
        @(posedge clock); #1;
        check("rst_no_ack", 32'(c_ack | l_ack), 0);
        c_req = 1'b1; c_we = 1'b0; c_addr = 8'h10;
        run_access(1'b0, w);
        check("after_rst_rdata", 32'(c_rdata), 32'(ref_mem[16]));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
